// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised, optionally debounced inputs with sticky
// edge capture, interrupt mask and a level IRQ built from those two registers.
module pio_in_edge_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;
    logic             w_wr;
    logic             w_unused_wd;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_wr        = chipselect & ~write_n;
    assign w_unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    if (DEBOUNCE_CYCLES <= 1) begin : g_nodeb
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stable <= '0;
            end else begin
                r_stable <= w_s;
            end
        end
    end else begin : g_deb
        localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
        logic [CW-1:0] r_cnt [WIDTH];

        // Per-bit run length of samples disagreeing with the filtered value.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stable <= '0;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (w_s[i] == r_stable[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_stable[i] <= w_s[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       w_event = r_stable & ~r_prev;
            1:       w_event = ~r_stable & r_prev;
            default: w_event = r_stable ^ r_prev;
        endcase
    end

    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdmux = '0;
        case (address)
            2'd0:    w_rdmux[WIDTH-1:0] = r_stable;
            2'd2:    w_rdmux[WIDTH-1:0] = r_mask;
            2'd3:    w_rdmux[WIDTH-1:0] = r_cap;
            default: w_rdmux = '0;
        endcase
    end

    // A new event overrides a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_cap      <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
        end else begin
            r_prev     <= r_stable;
            r_cap      <= (r_cap & ~w_clr) | w_event;
            r_readdata <= w_rdmux;
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two instances (plain rising-edge, and debounced
// any-edge) checked every cycle against a history-based reference model.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in0, in1;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    // Model: histories indexed by clock edges since reset release.
    logic [3:0]  in0_h [4096];
    logic [3:0]  in1_h [4096];
    logic [3:0]  st0_h [4096];
    logic [3:0]  st1_h [4096];
    logic [3:0]  mask_m, cap0_m, cap1_m;
    logic [31:0] rd0_m, rd1_m;
    int          n = 0;

    function automatic logic [3:0] s1_at(int j);
        return (j >= 1) ? in1_h[j-1] : 4'h0;
    endfunction

    function automatic logic [3:0] st0_at(int j);
        return (j >= 0) ? st0_h[j] : 4'h0;
    endfunction

    function automatic logic [3:0] st1_at(int j);
        return (j >= 0) ? st1_h[j] : 4'h0;
    endfunction

    function automatic logic [31:0] mux_m(logic [1:0] a, logic [3:0] st, logic [3:0] cap);
        case (a)
            2'd0:    return {28'h0, st};
            2'd2:    return {28'h0, mask_m};
            2'd3:    return {28'h0, cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        in0_h[0] = 4'h0; in1_h[0] = 4'h0;
        st0_h[0] = 4'h0; st1_h[0] = 4'h0;
        mask_m = 4'h0; cap0_m = 4'h0; cap1_m = 4'h0;
        rd0_m = 32'h0; rd1_m = 32'h0;
    endtask

    task automatic model_edge(logic wr, logic [1:0] a, logic [31:0] d);
        logic [3:0] old1, new1, ev0, ev1, clr;
        logic       flip;
        st0_h[n] = (n >= 2) ? in0_h[n-2] : 4'h0;
        // Debounced value flips once 8 consecutive synchronised samples disagree.
        old1 = st1_h[n-1];
        new1 = old1;
        for (int b = 0; b < 4; b++) begin
            flip = (n >= 8);
            for (int j = n - 8; j < n; j++) begin
                if (j >= 0 && s1_at(j)[b] == old1[b]) flip = 1'b0;
            end
            if (flip) new1[b] = ~old1[b];
        end
        st1_h[n] = new1;
        rd0_m = mux_m(a, st0_at(n-1), cap0_m);
        rd1_m = mux_m(a, st1_at(n-1), cap1_m);
        ev0 = st0_at(n-1) & ~st0_at(n-2);
        ev1 = st1_at(n-1) ^ st1_at(n-2);
        clr = (wr && a == 2'd3) ? d[3:0] : 4'h0;
        cap0_m = (cap0_m & ~clr) | ev0;
        cap1_m = (cap1_m & ~clr) | ev1;
        if (wr && a == 2'd2) mask_m = d[3:0];
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic       wr;
        logic [1:0] a;
        logic [31:0] d;
        in0_h[n+1] = in0;
        in1_h[n+1] = in1;
        wr = chipselect && !write_n;
        a  = address;
        d  = writedata;
        @(posedge clk);
        n++;
        model_edge(wr, a, d);
        @(negedge clk);
        chk("rd0", rd0, rd0_m);
        chk("rd1", rd1, rd1_m);
        chk("irq0", {31'h0, irq0}, {31'h0, |(cap0_m & mask_m)});
        chk("irq1", {31'h0, irq1}, {31'h0, |(cap1_m & mask_m)});
    endtask

    task automatic ticks(int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_irq0", {31'h0, irq0}, 32'h0);
        chk("rst_irq1", {31'h0, irq1}, 32'h0);
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in0 = 4'h0; in1 = 4'h0;
        @(negedge clk);
        do_reset();

        // Basic latency: stable after edge 3, capture and data readback after edge 4.
        in0 = 4'b0101;
        ticks(4);
        chk("t1_data", rd0, 32'h5);
        address = 2'd3;
        tick();
        chk("t1_cap", rd0, 32'h5);

        // IRQ masking and write-1-to-clear.
        in0 = 4'h0;
        do_reset();
        bus_write(2'd2, 32'h2);
        in0 = 4'b0001;
        ticks(5);
        chk("t3_irq_b0", {31'h0, irq0}, 32'h0);
        in0 = 4'b0011;
        ticks(5);
        chk("t3_irq_b1", {31'h0, irq0}, 32'h1);
        bus_write(2'd3, 32'h2);
        chk("t3_irq_clr", {31'h0, irq0}, 32'h0);
        address = 2'd3;
        tick();
        chk("t3_cap", rd0, 32'h1);

        // Clear and new event on bit 2 land on the same edge.
        in0 = 4'b0111;
        ticks(3);
        bus_write(2'd3, 32'h4);
        address = 2'd3;
        tick();
        chk("t4_race", rd0, 32'h5);

        // Debounce: a 5-cycle glitch is filtered, an 8-cycle hold passes.
        address = 2'd0;
        in1 = 4'h1;
        ticks(5);
        in1 = 4'h0;
        ticks(12);
        chk("t2_glitch", rd1, 32'h0);
        in1 = 4'h1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) chk("t2_hold_early", rd1, 32'h0);
            if (i == 11) chk("t2_hold", rd1, 32'h1);
        end

        // Any-edge capture on bit 3, re-armed by a clear between transitions.
        bus_write(2'd3, 32'hF);
        in1 = 4'b1001;
        address = 2'd3;
        ticks(12);
        chk("t5_rise", rd1, 32'h8);
        bus_write(2'd3, 32'h8);
        in1 = 4'b0001;
        address = 2'd3;
        ticks(12);
        chk("t5_fall", rd1, 32'h8);

        // Reset while interrupting and while a mask write is on the bus.
        in0 = 4'h0;
        do_reset();
        bus_write(2'd2, 32'hF);
        in0 = 4'hF;
        ticks(6);
        chk("t6_irq_pre", {31'h0, irq0}, 32'h1);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h5;
        do_reset();
        chk("t6_irq_post", {31'h0, irq0}, 32'h0);
        chipselect = 1'b0; write_n = 1'b1;
        tick();
        chk("t6_mask", rd0, 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0)  in0 = 4'($urandom);
            if ($urandom_range(15) == 0) in1 = 4'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(3) != 0);
            writedata  = $urandom;
            if ($urandom_range(299) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
